// File: rtl/abm_bit_setter_if.sv
// rtl/abm_bit_setter_if.sv - bit-index stream into the bitmap bit setter
interface abm_bit_setter_if #(
  parameter int IW = 23
);
  logic [IW-1:0] idx_tdata;
  logic          idx_tvalid;
  logic          idx_tready;

  modport master (output idx_tdata, output idx_tvalid, input idx_tready);
  modport slave  (input idx_tdata, input idx_tvalid, output idx_tready);
endinterface

// File: rtl/abm_bit_setter.sv
// rtl/abm_bit_setter.sv - sets bitmap bits in one SDP RAM bank by read-modify-write
// Self-clears the bank after reset and on request so readers always see a clean map.
module abm_bit_setter #(
  parameter int DW = 512,
  parameter int DD = 16384,
  localparam int AW = $clog2(DD),
  localparam int BW = $clog2(DW),
  localparam int IW = AW + BW
) (
  input  logic                clk,
  input  logic                reset,
  abm_bit_setter_if.slave     idx,
  input  logic                clear,
  output logic                busy,
  output logic [31:0]         set_count,
  output logic [AW-1:0]       ram_rd_addr,
  input  logic [DW-1:0]       ram_rd_data,
  output logic [AW-1:0]       ram_wr_addr,
  output logic [DW-1:0]       ram_wr_data,
  output logic                ram_wr_en
);

  typedef enum logic [2:0] {
    CLEAR_START,
    CLEARING,
    IDLE,
    RD_WAIT,
    MODIFY,
    WR_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DD - 1);
  localparam logic [DW-1:0] ONE_BIT   = {{(DW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic          tready_q, tready_d;
  logic          busy_q, busy_d;
  logic          wr_en_q, wr_en_d;
  logic [31:0]   set_count_q, set_count_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          clear_pending_q, clear_pending_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= CLEAR_START;
      tready_q        <= 1'b0;
      busy_q          <= 1'b0;
      wr_en_q         <= 1'b0;
      set_count_q     <= '0;
      rd_addr_q       <= '0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      bit_q           <= '0;
      clear_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      tready_q        <= tready_d;
      busy_q          <= busy_d;
      wr_en_q         <= wr_en_d;
      set_count_q     <= set_count_d;
      rd_addr_q       <= rd_addr_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      bit_q           <= bit_d;
      clear_pending_q <= clear_pending_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    tready_d        = tready_q;
    busy_d          = busy_q;
    wr_en_d         = 1'b0;
    set_count_d     = set_count_q;
    rd_addr_d       = rd_addr_q;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;
    bit_d           = bit_q;
    clear_pending_d = clear_pending_q;

    case (state_q)
      CLEAR_START: begin
        busy_d          = 1'b1;
        wr_addr_d       = '0;
        wr_data_d       = '0;
        wr_en_d         = 1'b1;
        set_count_d     = '0;
        clear_pending_d = 1'b0;
        state_d         = CLEARING;
      end
      CLEARING: begin
        if (wr_addr_q == LAST_ADDR) begin
          busy_d   = 1'b0;
          tready_d = 1'b1;
          state_d  = IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
        end
      end
      IDLE: begin
        // A clear wins over an index offered in the same cycle.
        if (clear || clear_pending_q) begin
          tready_d = 1'b0;
          state_d  = CLEAR_START;
        end else if (idx.idx_tvalid && tready_q) begin
          rd_addr_d   = idx.idx_tdata[IW-1:BW];
          bit_d       = idx.idx_tdata[BW-1:0];
          tready_d    = 1'b0;
          set_count_d = set_count_q + 32'd1;
          state_d     = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (clear) clear_pending_d = 1'b1;
        state_d = MODIFY;
      end
      MODIFY: begin
        if (clear) clear_pending_d = 1'b1;
        wr_addr_d = rd_addr_q;
        wr_data_d = ram_rd_data | (ONE_BIT << bit_q);
        wr_en_d   = 1'b1;
        state_d   = WR_DONE;
      end
      WR_DONE: begin
        if (clear) clear_pending_d = 1'b1;
        tready_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = CLEAR_START;
    endcase
  end

  assign idx.idx_tready = tready_q;
  assign busy           = busy_q;
  assign set_count      = set_count_q;
  assign ram_rd_addr    = rd_addr_q;
  assign ram_wr_addr    = wr_addr_q;
  assign ram_wr_data    = wr_data_q;
  assign ram_wr_en      = wr_en_q;

endmodule

// File: tb/tb_abm_bit_setter.sv
// tb/tb_abm_bit_setter.sv - scoreboard bench for abm_bit_setter with a bitmap reference model
module tb_abm_bit_setter;
  localparam int DW = 512;
  localparam int DD = 16;
  localparam int AW = 4;
  localparam int BW = 9;
  localparam int IW = AW + BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          busy;
  logic [31:0]   set_count;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_wr_en;

  abm_bit_setter_if #(.IW(IW)) idx_if ();

  abm_bit_setter #(.DW(DW), .DD(DD)) dut (
    .clk         (clk),
    .reset       (reset),
    .idx         (idx_if),
    .clear       (clear),
    .busy        (busy),
    .set_count   (set_count),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_wr_en   (ram_wr_en)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DD];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] model_map [DD];
  int            model_cnt;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_clear();
    for (int i = 0; i < DD; i++) begin
      push_wr(AW'(i), '0);
      model_map[i] = '0;
    end
    model_cnt = 0;
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!reset && ram_wr_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", ram_wr_addr, ram_wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", DW'(ram_wr_addr), DW'(e.a));
        chk("wr_data", ram_wr_data, e.d);
      end
    end
  end

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_idx(input logic [IW-1:0] v);
    logic [AW-1:0] w;
    logic [BW-1:0] b;
    idx_if.idx_tdata  = v;
    idx_if.idx_tvalid = 1'b1;
    for (int t = 0; t < 200 && !idx_if.idx_tready; t++) @(negedge clk);
    if (!idx_if.idx_tready) begin
      timeout_fail("send_idx");
      idx_if.idx_tvalid = 1'b0;
      return;
    end
    w = v[IW-1:BW];
    b = v[BW-1:0];
    model_map[w][b] = 1'b1;
    push_wr(w, model_map[w]);
    model_cnt++;
    @(negedge clk);
    idx_if.idx_tvalid = 1'b0;
    idx_if.idx_tdata  = IW'($urandom);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 4 * DD + 50 && !idx_if.idx_tready; t++) @(negedge clk);
    if (!idx_if.idx_tready) timeout_fail("wait_idle");
  endtask

  task automatic wait_clear_done();
    for (int t = 0; t < 20 && !busy; t++) @(negedge clk);
    if (!busy) timeout_fail("clear_start");
    wait_idle();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    push_clear();
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},      DW'(busy), '0);
    chk({tag, "_tready"},    DW'(idx_if.idx_tready), '0);
    chk({tag, "_wr_en"},     DW'(ram_wr_en), '0);
    chk({tag, "_set_count"}, DW'(set_count), '0);
    chk({tag, "_rd_addr"},   DW'(ram_rd_addr), '0);
    chk({tag, "_wr_addr"},   DW'(ram_wr_addr), '0);
    chk({tag, "_wr_data"},   ram_wr_data, '0);
  endtask

  initial begin
    int            first_busy;
    int            fall;
    int            wen_cnt;
    logic [4:0]    pat;
    logic [DW-1:0] acc;
    logic [IW-1:0] v;
    int            r;

    reset = 1'b1;
    clear = 1'b0;
    idx_if.idx_tvalid = 1'b0;
    idx_if.idx_tdata  = '0;
    for (int i = 0; i < DD; i++) model_map[i] = '0;
    model_cnt = 0;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");

    // Power-up clear: busy from the first edge, falls DD+1 cycles after release.
    push_clear();
    reset = 1'b0;
    first_busy = -1;
    fall = -1;
    wen_cnt = 0;
    for (int t = 1; t <= DD + 40 && fall < 0; t++) begin
      @(negedge clk);
      if (ram_wr_en) wen_cnt++;
      if (busy && first_busy < 0) first_busy = t;
      if (!busy && first_busy >= 0) fall = t;
    end
    chk("busy_rise_cycle", DW'(first_busy), DW'(1));
    chk("busy_fall_cycle", DW'(fall), DW'(DD + 1));
    chk("clear_write_count", DW'(wen_cnt), DW'(DD));
    chk("tready_after_clear", DW'(idx_if.idx_tready), DW'(1));
    chk("set_count_after_clear", DW'(set_count), '0);

    // Single index: word 1, bit 5.
    send_idx(13'h205);
    wait_idle();
    chk("set_count_single", DW'(set_count), DW'(model_cnt));
    chk("queue_drained_single", DW'(exp_q.size()), '0);

    // Back-to-back on word 0 with tready pattern 1,0,0,0,1.
    pat[4] = idx_if.idx_tready;
    send_idx(13'd3);
    pat[3] = idx_if.idx_tready;
    @(negedge clk); pat[2] = idx_if.idx_tready;
    @(negedge clk); pat[1] = idx_if.idx_tready;
    @(negedge clk); pat[0] = idx_if.idx_tready;
    chk("tready_pattern", DW'(pat), DW'(5'b10001));
    send_idx(13'd7);
    wait_idle();
    chk("set_count_b2b", DW'(set_count), DW'(model_cnt));

    // Clear during MODIFY: in-flight write lands, then full clear.
    send_idx(13'd10);
    @(negedge clk);
    pulse_clear();
    wait_clear_done();
    chk("set_count_after_mid_clear", DW'(set_count), '0);
    acc = '0;
    for (int i = 0; i < DD; i++) acc = acc | mem[i];
    chk("mem_all_zero", acc, '0);

    // Clear and tvalid together in IDLE: index waits until after the clear.
    v = {4'd2, 9'd192};
    idx_if.idx_tdata  = v;
    idx_if.idx_tvalid = 1'b1;
    pulse_clear();
    chk("tready_drop_on_clear", DW'(idx_if.idx_tready), '0);
    chk("no_accept_on_clear", DW'(set_count), '0);
    send_idx(v);
    wait_idle();
    chk("set_count_after_deferred", DW'(set_count), DW'(1));

    // Async reset mid-clear at address 6.
    pulse_clear();
    for (int t = 0; t < 40 && !(ram_wr_en && ram_wr_addr == AW'(6)); t++) @(negedge clk);
    if (!(ram_wr_en && ram_wr_addr == AW'(6))) timeout_fail("reach_addr6");
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    push_clear();
    reset = 1'b0;
    @(negedge clk);
    chk("restart_addr0", DW'({ram_wr_en, ram_wr_addr}), DW'({1'b1, 4'd0}));
    wait_clear_done();

    // Randomised indices with occasional clears.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        wait_idle();
        pulse_clear();
        wait_clear_done();
      end else if (r == 1) begin
        send_idx(IW'($urandom));
        pulse_clear();
        wait_clear_done();
      end else begin
        send_idx(IW'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    wait_idle();
    repeat (2) @(negedge clk);
    chk("final_queue_empty", DW'(exp_q.size()), '0);
    chk("final_set_count", DW'(set_count), DW'(model_cnt));
    for (int i = 0; i < DD; i++) chk("final_map", mem[i], model_map[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
